// File: rtl/ccg_eval_pkg.sv
// ----------------------------------------------------------------------------
// ccg_eval_pkg
//   Shared types and constants for the exhaustive CUT evaluation sequencer:
//   the sequencer state encoding, the default MISR polynomial and seed, and a
//   16-bit MISR step function that the sequencer's harness can use as a
//   reference model of the signature.
// ----------------------------------------------------------------------------
package ccg_eval_pkg;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        CAPTURE,
        DONE
    } state_e;

    localparam int          SIG_W_DEF    = 16;
    localparam logic [15:0] SIG_POLY_DEF = 16'h1021;
    localparam logic [15:0] SIG_SEED_DEF = 16'hFFFF;

    // One MISR compaction step at the default width: shift left, fold the
    // outgoing MSB back through the polynomial taps, then absorb the data word.
    function automatic logic [15:0] misr_step(input logic [15:0] sig,
                                              input logic [15:0] poly,
                                              input logic [15:0] data);
        return {sig[14:0], 1'b0} ^ (sig[15] ? poly : 16'h0000) ^ data;
    endfunction

endpackage

// File: rtl/ccg_misr.sv
// ----------------------------------------------------------------------------
// ccg_misr
//   Multiple-input signature register used to compact CUT responses.
//   Ports:
//     clk, rst_n   clock and asynchronous active-low reset (state clears to 0)
//     load_i       load SIG_SEED (takes priority over step_i)
//     step_i       absorb data_i into the signature this cycle
//     data_i       SIG_W-bit word to compact
//     sig_o        current signature
// ----------------------------------------------------------------------------
module ccg_misr
    import ccg_eval_pkg::*;
#(
    parameter int               SIG_W    = SIG_W_DEF,
    parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(SIG_POLY_DEF),
    parameter logic [SIG_W-1:0] SIG_SEED = SIG_W'(SIG_SEED_DEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [SIG_W-1:0] data_i,
    output logic [SIG_W-1:0] sig_o
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    // NOTE: next-state logic starts from a hold default so every path assigns
    // sig_d and no latch is inferred.
    always_comb begin
        sig_d = sig_q;
        if (load_i) begin
            sig_d = SIG_SEED;
        end else if (step_i) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? SIG_POLY : '0)
                  ^ data_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/ccg_eval_sequencer.sv
// ----------------------------------------------------------------------------
// ccg_eval_sequencer
//   Exhaustively sweeps a combinational circuit-under-test: applies every
//   input vector 0..2^N_IN-1, holds it SETTLE cycles, captures the response,
//   streams it over a valid/ready port and compacts accepted responses into a
//   MISR signature.
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     start                begin a sweep (honoured only in IDLE)
//     abort                synchronous abort back to IDLE, no done pulse
//     cut_x  / cut_f       stimulus to / response from the CUT
//     rsp_valid/rsp_ready  response handshake
//     rsp_vec / rsp_f      vector index and captured response of a beat
//     busy                 sweep in progress
//     done                 one-cycle pulse at sweep completion
//     signature            MISR result, stable from done until next start
// ----------------------------------------------------------------------------
module ccg_eval_sequencer
    import ccg_eval_pkg::*;
#(
    parameter int               N_IN     = 7,
    parameter int               N_OUT    = 4,
    parameter int               SETTLE   = 2,
    parameter int               SIG_W    = SIG_W_DEF,
    parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(SIG_POLY_DEF),
    parameter logic [SIG_W-1:0] SIG_SEED = SIG_W'(SIG_SEED_DEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [N_IN-1:0]  cut_x,
    input  logic [N_OUT-1:0] cut_f,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [N_IN-1:0]  rsp_vec,
    output logic [N_OUT-1:0] rsp_f,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_e           state_q;
    logic [N_IN-1:0]  cut_x_q;
    logic [3:0]       settle_q;
    logic             rsp_valid_q;
    logic [N_IN-1:0]  rsp_vec_q;
    logic [N_OUT-1:0] rsp_f_q;
    logic             busy_q;
    logic             done_q;

    logic misr_load;
    logic misr_step_en;

    // Seed on an honoured start; compact only beats actually accepted.
    // Abort beats a coincident start or accept, leaving the signature as is.
    assign misr_load    = (state_q == IDLE) && start && !abort;
    assign misr_step_en = (state_q == CAPTURE) && rsp_valid_q && rsp_ready && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cut_x_q     <= '0;
            settle_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_vec_q   <= '0;
            rsp_f_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort && state_q != IDLE) begin
                // cut_x and the captured beat are deliberately left untouched.
                state_q     <= IDLE;
                rsp_valid_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start && !abort) begin
                            state_q  <= APPLY;
                            busy_q   <= 1'b1;
                            cut_x_q  <= '0;
                            settle_q <= '0;
                        end
                    end
                    APPLY: begin
                        if (settle_q == SETTLE_LAST) begin
                            state_q     <= CAPTURE;
                            rsp_valid_q <= 1'b1;
                            rsp_vec_q   <= cut_x_q;
                            rsp_f_q     <= cut_f;
                        end else begin
                            settle_q <= settle_q + 4'd1;
                        end
                    end
                    CAPTURE: begin
                        if (rsp_ready) begin
                            rsp_valid_q <= 1'b0;
                            if (&cut_x_q) begin
                                // Last vector: finish without wrapping cut_x.
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q  <= APPLY;
                                cut_x_q  <= cut_x_q + N_IN'(1);
                                settle_q <= '0;
                            end
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    ccg_misr #(
        .SIG_W    (SIG_W),
        .SIG_POLY (SIG_POLY),
        .SIG_SEED (SIG_SEED)
    ) u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (misr_load),
        .step_i (misr_step_en),
        .data_i (SIG_W'(rsp_f_q)),
        .sig_o  (signature)
    );

    assign cut_x     = cut_x_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_vec   = rsp_vec_q;
    assign rsp_f     = rsp_f_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ccg_eval_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ccg_eval_sequencer
//   Directed bench for ccg_eval_sequencer at default parameters with a CUT
//   model f = x[3:0]. Expected signatures come from the package MISR step.
// ----------------------------------------------------------------------------
module tb_ccg_eval_sequencer;
    import ccg_eval_pkg::*;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        start     = 1'b0;
    logic        abort     = 1'b0;
    logic        rsp_ready = 1'b1;
    logic [6:0]  cut_x;
    logic [3:0]  cut_f;
    logic        rsp_valid;
    logic [6:0]  rsp_vec;
    logic [3:0]  rsp_f;
    logic        busy;
    logic        done;
    logic [15:0] signature;

    int checks = 0;
    int errors = 0;

    assign cut_f = cut_x[3:0];

    always #5 clk = ~clk;

    ccg_eval_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .cut_x     (cut_x),
        .cut_f     (cut_f),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_vec   (rsp_vec),
        .rsp_f     (rsp_f),
        .busy      (busy),
        .done      (done),
        .signature (signature)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_sig(input int nbeats);
        logic [15:0] s = SIG_SEED_DEF;
        for (int i = 0; i < nbeats; i++) begin
            s = misr_step(s, SIG_POLY_DEF, 16'(i & 15));
        end
        return s;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cut_x"},     cut_x,     0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_vec"},   rsp_vec,   0);
        check({tag, "_rsp_f"},     rsp_f,     0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_done"},      done,      0);
        check({tag, "_signature"}, signature, 0);
    endtask

    // One sweep from IDLE. bp_vec: stall that beat 5 cycles; abort_vec: abort
    // while that vector is in APPLY; rst_vec: async reset while that beat is
    // in CAPTURE; poke_start: pulse start mid-sweep. Negative disables.
    task automatic sweep(input int bp_vec, input int abort_vec, input int rst_vec,
                         input bit poke_start, input int exp_edges);
        int edges = 0;
        int beats = 0;
        int stall = 0;
        bit poked = 1'b0;
        rsp_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 1;
        check("start_busy",  busy,      1);
        check("start_cut_x", cut_x,     0);
        check("start_seed",  signature, SIG_SEED_DEF);
        check("start_valid", rsp_valid, 0);
        while (!done && edges < 2000) begin
            if (rsp_valid) begin
                check("beat_vec", rsp_vec, beats);
                check("beat_f",   rsp_f,   beats & 15);
                if (beats == rst_vec) begin
                    rsp_ready = 1'b0;
                    #2 rst_n = 1'b0;
                    #1;
                    check_reset_outputs("async_rst");
                    repeat (3) begin
                        @(posedge clk); #1;
                        check("rst_hold_done", done, 0);
                    end
                    rst_n = 1'b1;
                    repeat (4) begin
                        @(posedge clk); #1;
                        check("rst_after_done", done, 0);
                        check("rst_after_busy", busy, 0);
                    end
                    return;
                end
                if (beats == bp_vec && stall < 5) begin
                    rsp_ready = 1'b0;
                    stall++;
                end else begin
                    rsp_ready = 1'b1;
                    beats++;
                end
            end else begin
                rsp_ready = 1'b1;
                if (busy && cut_x == abort_vec) begin
                    abort = 1'b1;
                    @(posedge clk); #1;
                    abort = 1'b0;
                    check("abort_busy",  busy,      0);
                    check("abort_valid", rsp_valid, 0);
                    check("abort_done",  done,      0);
                    check("abort_cut_x", cut_x,     abort_vec);
                    check("abort_sig",   signature, model_sig(abort_vec));
                    repeat (5) begin
                        @(posedge clk); #1;
                        check("abort_no_done", done, 0);
                        check("abort_idle",    busy, 0);
                    end
                    return;
                end
            end
            if (poke_start && !poked && cut_x == 7'd20) begin
                start = 1'b1;
                poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
        end
        start = 1'b0;
        check("done_seen",  done,      1);
        check("done_edge",  edges,     exp_edges);
        check("beat_count", beats,     128);
        check("done_sig",   signature, model_sig(128));
        check("done_busy",  busy,      0);
        check("done_valid", rsp_valid, 0);
        check("no_wrap",    cut_x,     7'd127);
        @(posedge clk); #1;
        check("done_pulse", done,      0);
        check("sig_stable", signature, model_sig(128));
        check("idle_busy",  busy,      0);
    endtask

    initial begin
        // 1: reset and idle
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("in_reset");
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            check("idle_valid", rsp_valid, 0);
            check("idle_busy0", busy,      0);
        end
        check_reset_outputs("after_idle");

        // 2: full sweep, sink always ready
        sweep(-1, -1, -1, 1'b0, 385);

        // 3: backpressure on vector 37
        sweep(37, -1, -1, 1'b0, 390);

        // 4: abort on vector 64 in APPLY, then a clean restart
        sweep(-1, 64, -1, 1'b0, 0);
        sweep(-1, -1, -1, 1'b0, 385);

        // 5: start while busy, then start+abort together in IDLE
        sweep(-1, -1, -1, 1'b1, 385);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy",  busy,      0);
        check("sa_valid", rsp_valid, 0);
        check("sa_cut_x", cut_x,     7'd127);
        check("sa_sig",   signature, model_sig(128));
        repeat (3) begin
            @(posedge clk); #1;
            check("sa_stay_idle", busy, 0);
        end

        // 6: async reset during CAPTURE of vector 10
        sweep(-1, -1, 10, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
